// File: rtl/mem_access_unit_if.sv
// Bundle between the pipeline's load/store requester, the access unit
// and the word-addressed data memory. The access unit uses the slave
// modport; the pipeline/memory side uses the master modport.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests
// into accesses on a word-only memory with 1-cycle synchronous read/write.
// Sub-word loads read then extract; sub-word stores read-modify-write.
// Byte order is big-endian (byte offset 0 lives in bits [31:24]).
// Optional build macro MAU_ALIGN_CHECK_EN: misaligned halfword/word
// requests and addresses beyond MEM_WORDS are answered with err instead
// of touching memory. Without it only size=11 is an error.
module mem_access_unit #(
  parameter int MEM_WORDS = 32
) (
  input  logic clk,
  input  logic reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    MRG,
    WR,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        ready_c;
  logic        mem_read_c;
  logic        mem_write_c;
  logic [31:0] mem_wdata_c;

  logic        accept;
  logic        out_of_range;
  logic        req_bad;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_value;
  logic [31:0] merge_value;

  assign accept       = (state == IDLE) && bus.req;
  assign out_of_range = ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS));

`ifdef MAU_ALIGN_CHECK_EN
  assign req_bad = (bus.size == 2'b11)
                 | ((bus.size == 2'b01) && bus.addr[0])
                 | ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00))
                 | out_of_range;
`else
  // Without the check the range compare has no consumer; keep it visibly parked.
  logic range_unused;
  assign range_unused = out_of_range;
  assign req_bad      = (bus.size == 2'b11);
`endif

  // State register; reset abandons whatever access is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and memory strobes; strobes are gated with reset so no access happens on a reset edge.
  always_comb begin
    state_next  = state;
    ready_c     = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_wdata_c = lat_wdata;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req) begin
          if (req_bad) begin
            state_next = ERR;
          end else if (bus.we && (bus.size == 2'b10)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        mem_read_c = !reset;
        state_next = lat_we ? MRG : CAP;
      end
      CAP: begin
        state_next = IDLE;
      end
      MRG: begin
        mem_write_c = !reset;
        mem_wdata_c = merge_value;
        state_next  = IDLE;
      end
      WR: begin
        mem_write_c = !reset;
        state_next  = IDLE;
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the memory word and extend it.
  always_comb begin
    case (lat_addr[1:0])
      2'd0:    sel_byte = bus.mem_rdata[31:24];
      2'd1:    sel_byte = bus.mem_rdata[23:16];
      2'd2:    sel_byte = bus.mem_rdata[15:8];
      default: sel_byte = bus.mem_rdata[7:0];
    endcase
    sel_half = lat_addr[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
    case (lat_size)
      2'b00:   load_value = lat_sign ? {{24{sel_byte[7]}}, sel_byte} : {24'h000000, sel_byte};
      2'b01:   load_value = lat_sign ? {{16{sel_half[15]}}, sel_half} : {16'h0000, sel_half};
      default: load_value = bus.mem_rdata;
    endcase
  end

  // Replace only the addressed lane of the word just read; everything else is kept.
  always_comb begin
    merge_value = bus.mem_rdata;
    case (lat_size)
      2'b00: begin
        case (lat_addr[1:0])
          2'd0:    merge_value[31:24] = lat_wdata[7:0];
          2'd1:    merge_value[23:16] = lat_wdata[7:0];
          2'd2:    merge_value[15:8]  = lat_wdata[7:0];
          default: merge_value[7:0]   = lat_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lat_addr[1]) begin
          merge_value[15:0] = lat_wdata[15:0];
        end else begin
          merge_value[31:16] = lat_wdata[15:0];
        end
      end
      default: merge_value = lat_wdata;
    endcase
  end

  // Operand latch at acceptance, completion pulse, error flag and held load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_sign  <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      done_q <= (state == CAP) || (state == MRG) || (state == WR) || (state == ERR);
      err_q  <= (state == ERR);
      if (accept) begin
        lat_we    <= bus.we;
        lat_size  <= bus.size;
        lat_sign  <= bus.sign_ext;
        lat_addr  <= bus.addr;
        lat_wdata <= bus.wdata;
      end
      if (state == CAP) begin
        rdata_q <= load_value;
      end
    end
  end

  assign bus.ready     = ready_c;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = {2'b00, lat_addr[31:2]};
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;

endmodule
